cv32e40px_xregfile: RTL

- Next-generation flip-flop register file for the CV32E40PX core.
- Generalised to NUM_RPORTS read ports and NUM_WPORTS write ports, each able to do a single-word or an aligned register-pair access.
- Optional FP bank; address bit 5 selects it.
- Adds a per-register busy scoreboard for outstanding X-interface (coprocessor) writebacks, so decode can stall on hazards without an external tracker.

---
 rtl/cv32e40px_xrf_pkg.sv | 33 +++
 rtl/cv32e40px_xrf_scoreboard.sv | 73 +++++++
 rtl/cv32e40px_xregfile.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cv32e40px_xrf_pkg.sv
// cv32e40px_xrf_pkg
// Shared definitions for the CV32E40PX extended register file.
// Holds the bank/index geometry, the two-word pair container type and the
// helpers that turn an access address into its word0/word1 register slots.
// No ports (package).

package cv32e40px_xrf_pkg;

  localparam int RF_IDX_W    = 5;
  localparam int RF_BANK_BIT = 5;
  localparam int RF_DATA_W   = 32;

  // One register pair as seen on a read or write port: hi is word1, lo is word0
  typedef struct packed {
    logic [RF_DATA_W-1:0] hi;
    logic [RF_DATA_W-1:0] lo;
  } rf_word_t;

  // word0 slot: the address itself for single accesses, LSB cleared for pairs
  function automatic logic [RF_IDX_W:0] pair_lo(input logic [RF_IDX_W:0] addr,
                                                input logic              pair);
    logic [RF_IDX_W:0] res;
    res = addr;
    if (pair) res[0] = 1'b0;
    return res;
  endfunction

  // word1 slot: always the odd register of the aligned pair
  function automatic logic [RF_IDX_W:0] pair_hi(input logic [RF_IDX_W:0] addr);
    return {addr[RF_IDX_W:1], 1'b1};
  endfunction

endpackage

// File: rtl/cv32e40px_xrf_scoreboard.sv
// cv32e40px_xrf_scoreboard
// Per-register busy bits tracking outstanding coprocessor writebacks.
// Optional macro: CV32E40PX_RF_BYPASS_EN (busy clears become visible to the
// read ports in the same cycle as the clearing write).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   valid              which register slots physically exist (x0 never does)
//   clr                per-register "written this cycle" vector
//   sb_set/sb_addr/sb_pair  mark a destination (or pair) busy
//   sb_flush           clear every busy bit, beats sb_set
//   raddr/rpair        read-port addresses and pair flags
//   rbusy              per read port: addressed word(s) busy
//   busy_any           OR of all registered busy bits

module cv32e40px_xrf_scoreboard
  import cv32e40px_xrf_pkg::*;
#(
  parameter int NUM_RPORTS = 3,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REGS-1:0]                   valid,
  input  logic [NUM_REGS-1:0]                   clr,
  input  logic                                  sb_set,
  input  logic [ADDR_WIDTH-1:0]                 sb_addr,
  input  logic                                  sb_pair,
  input  logic                                  sb_flush,
  input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr,
  input  logic [NUM_RPORTS-1:0]                 rpair,
  output logic [NUM_RPORTS-1:0]                 rbusy,
  output logic                                  busy_any
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] busy_view;

  // Set is applied after clear so a fresh issue survives an old retire
  always_comb begin
    set_vec = '0;
    if (sb_set) begin
      set_vec[pair_lo(sb_addr, sb_pair)] = 1'b1;
      if (sb_pair) set_vec[pair_hi(sb_addr)] = 1'b1;
    end
    set_vec = set_vec & valid;
    busy_d  = sb_flush ? '0 : ((busy_q & ~clr) | set_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef CV32E40PX_RF_BYPASS_EN
  assign busy_view = busy_q & ~clr;
`else
  assign busy_view = busy_q;
`endif

  always_comb begin
    rbusy = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rbusy[p] = busy_view[pair_lo(raddr[p], rpair[p])] |
                 (rpair[p] & busy_view[pair_hi(raddr[p])]);
    end
  end

  assign busy_any = |busy_q;

endmodule

// File: rtl/cv32e40px_xregfile.sv
// cv32e40px_xregfile
// Flip-flop register file for CV32E40PX: NUM_RPORTS read / NUM_WPORTS write
// ports, each doing a single-word or aligned pair access, optional FP bank
// (address bit 5, present only when FPU=1 and ZFINX=0) and a busy scoreboard
// for outstanding coprocessor writebacks.
// Optional macro: CV32E40PX_RF_BYPASS_EN forwards same-cycle write data to
// the read ports.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   raddr_i/rpair_i            read address / pair flag per read port
//   rdata_o                    read data per port, [1] = pair high word
//   rbusy_o                    addressed word(s) busy per read port
//   we_i/waddr_i/wpair_i/wdata_i  write ports, highest index wins
//   sb_set_i/sb_addr_i/sb_pair_i  mark destination busy
//   sb_flush_i                 clear all busy bits
//   busy_any_o                 any register busy

module cv32e40px_xregfile
  import cv32e40px_xrf_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3,
  parameter int NUM_WPORTS = 2,
  parameter int FPU        = 0,
  parameter int ZFINX      = 0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0]         raddr_i,
  input  logic [NUM_RPORTS-1:0]                         rpair_i,
  output logic [NUM_RPORTS-1:0][1:0][DATA_WIDTH-1:0]    rdata_o,
  output logic [NUM_RPORTS-1:0]                         rbusy_o,
  input  logic [NUM_WPORTS-1:0]                         we_i,
  input  logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0]         waddr_i,
  input  logic [NUM_WPORTS-1:0]                         wpair_i,
  input  logic [NUM_WPORTS-1:0][1:0][DATA_WIDTH-1:0]    wdata_i,
  input  logic                                          sb_set_i,
  input  logic [ADDR_WIDTH-1:0]                         sb_addr_i,
  input  logic                                          sb_pair_i,
  input  logic                                          sb_flush_i,
  output logic                                          busy_any_o
);

  localparam bit HAS_FP   = (FPU == 1) && (ZFINX == 0);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [NUM_REGS-1:0]   valid_mask;
  logic [NUM_REGS-1:0]   wr_en;
  logic [DATA_WIDTH-1:0] wr_data [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs    [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_view [NUM_REGS];

  // Ports are walked in ascending order so a higher-index port overrides a
  // lower one per register only. Enables are killed during reset so the
  // bypass cannot leak write data onto the read ports while rst_n is low.
  always_comb begin : write_decode
    logic [ADDR_WIDTH-1:0] lo;
    logic [ADDR_WIDTH-1:0] hi;
    lo    = '0;
    hi    = '0;
    wr_en = '0;
    for (int i = 0; i < NUM_REGS; i++) wr_data[i] = '0;
    if (rst_n) begin
      for (int w = 0; w < NUM_WPORTS; w++) begin
        if (we_i[w]) begin
          lo = pair_lo(waddr_i[w], wpair_i[w]);
          hi = pair_hi(waddr_i[w]);
          wr_en[lo]   = 1'b1;
          wr_data[lo] = wdata_i[w][0];
          if (wpair_i[w]) begin
            wr_en[hi]   = 1'b1;
            wr_data[hi] = wdata_i[w][1];
          end
        end
      end
    end
    wr_en = wr_en & valid_mask;
  end

  // x0 and (without an FP bank) the whole upper bank are hard-wired zero
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i != 0 && (i < (1 << RF_BANK_BIT) || HAS_FP)) begin : g_ff
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        q <= '0;
        else if (wr_en[i]) q <= wr_data[i];
      end
      assign regs[i]       = q;
      assign valid_mask[i] = 1'b1;
    end else begin : g_zero
      assign regs[i]       = '0;
      assign valid_mask[i] = 1'b0;
    end
`ifdef CV32E40PX_RF_BYPASS_EN
    assign rd_view[i] = wr_en[i] ? wr_data[i] : regs[i];
`else
    assign rd_view[i] = regs[i];
`endif
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rdata_o[p][0] = rd_view[pair_lo(raddr_i[p], rpair_i[p])];
      if (rpair_i[p]) rdata_o[p][1] = rd_view[pair_hi(raddr_i[p])];
    end
  end

  cv32e40px_xrf_scoreboard #(
    .NUM_RPORTS (NUM_RPORTS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid_mask),
    .clr      (wr_en),
    .sb_set   (sb_set_i),
    .sb_addr  (sb_addr_i),
    .sb_pair  (sb_pair_i),
    .sb_flush (sb_flush_i),
    .raddr    (raddr_i),
    .rpair    (rpair_i),
    .rbusy    (rbusy_o),
    .busy_any (busy_any_o)
  );

endmodule
